// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: line conditioning, frame deserializer and scan-code
// decoder producing a make code with a registered, multi-cycle press strobe.
`timescale 1ns/1ps
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PULSE_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // A valid frame carries an odd number of ones across data and parity.
  function automatic logic odd_ones9(input logic [8:0] v);
    return ^v;
  endfunction

  logic [1:0]    clk_sync_r, dat_sync_r;
  logic          filt_r, filt_prev_r;
  logic [FW-1:0] filt_cnt_r;
  logic          clk_s, dat_s, fall_s;
  state_t        state_r, state_n;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] tmo_r;
  logic          timeout_s, accept_s, err_s;
  logic          brk_r;
  logic [7:0]    held_r;
  logic [PW-1:0] pulse_cnt_r;
  logic          is_e0_s, is_f0_s, make_s, release_hit_s;

  assign clk_s     = clk_sync_r[1];
  assign dat_s     = dat_sync_r[1];
  assign fall_s    = filt_prev_r & ~filt_r;
  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (tmo_r == TW'(TIMEOUT_CYCLES - 1));

  // Two-stage synchronizers followed by the saturating glitch filter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      dat_sync_r  <= 2'b11;
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      dat_sync_r  <= {dat_sync_r[0], ps2_dat};
      filt_prev_r <= filt_r;
      if (clk_s != filt_r) begin
        if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
          filt_r     <= clk_s;
          filt_cnt_r <= '0;
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  // Receive FSM next state; a timeout aborts whatever frame is in flight.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    err_s    = 1'b0;
    if (timeout_s) begin
      state_n = ST_IDLE;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fall_s && !dat_s) state_n = ST_DATA;
          else                  state_n = ST_IDLE;
        end
        ST_DATA: begin
          if (fall_s && bit_cnt_r == 3'd7) state_n = ST_PARITY;
          else                             state_n = ST_DATA;
        end
        ST_PARITY: begin
          if (fall_s) state_n = ST_STOP;
          else        state_n = ST_PARITY;
        end
        ST_STOP: begin
          if (fall_s) begin
            state_n = ST_IDLE;
            if (dat_s && odd_ones9({parity_r, shift_r})) accept_s = 1'b1;
            else                                         err_s    = 1'b1;
          end else begin
            state_n = ST_STOP;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FSM state, bit shifter and in-frame idle timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      tmo_r     <= '0;
    end else begin
      state_r <= state_n;
      if (fall_s || state_r == ST_IDLE || timeout_s) tmo_r <= '0;
      else                                           tmo_r <= tmo_r + TW'(1);
      if (timeout_s) begin
        shift_r <= 8'h00;
      end else if (fall_s) begin
        case (state_r)
          ST_IDLE:   bit_cnt_r <= 3'd0;
          ST_DATA: begin
            shift_r   <= {dat_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          ST_PARITY: parity_r <= dat_s;
          default:   parity_r <= parity_r;
        endcase
      end
    end
  end

  // E0 has no effect on what the consumer sees, so it only shows on ps2_out.
  assign is_e0_s       = (shift_r == 8'hE0);
  assign is_f0_s       = (shift_r == 8'hF0);
  assign make_s        = accept_s && !is_e0_s && !is_f0_s && !brk_r && (shift_r != held_r);
  assign release_hit_s = brk_r && (shift_r == held_r);

  // Byte classification: break tracking, held-key repeat filter, outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2_out      <= 8'h00;
      ps2_key_data <= 8'h00;
      held_r       <= 8'h00;
      brk_r        <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= err_s;
      if (err_s) begin
        brk_r <= 1'b0;
      end else if (accept_s) begin
        ps2_out <= shift_r;
        if (is_f0_s) begin
          brk_r <= 1'b1;
        end else if (!is_e0_s) begin
          brk_r <= 1'b0;
          if (release_hit_s) held_r <= 8'h00;
          if (make_s) begin
            ps2_key_data <= shift_r;
            held_r       <= shift_r;
          end
        end
      end
    end
  end

  // Press strobe: reloadable down-counter, output registered once more.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_cnt_r     <= '0;
      ps2_key_pressed <= 1'b0;
    end else begin
      if (make_s)                   pulse_cnt_r <= PW'(PULSE_CYCLES);
      else if (pulse_cnt_r != '0)   pulse_cnt_r <= pulse_cnt_r - PW'(1);
      ps2_key_pressed <= (pulse_cnt_r != '0);
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios plus random byte streams
// compared against a byte-level model of the decoding rules.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

  localparam int TIMEOUT = 50000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_key_data, ps2_out;
  logic       ps2_key_pressed, frame_error;

  ps2_scan_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .PULSE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
    .ps2_out(ps2_out), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int half = 12;

  // observed event statistics
  int cyc = 0, kd_chg = 0, out_chg = 0, rise_lag = 0, out_lag = 0;
  int strobe_cnt = 0, ferr_cnt = 0, width = 0, fe_width = 0, bad_width = 0, bad_fe = 0;
  logic       kp_q = 1'b0, fe_q = 1'b0;
  logic [7:0] kd_q = 8'h00, out_q = 8'h00;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (ps2_key_data !== kd_q) kd_chg = cyc;
    if (ps2_out !== out_q) out_chg = cyc;
    if (ps2_key_pressed === 1'b1 && kp_q !== 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      rise_lag = cyc - kd_chg;
      out_lag = cyc - out_chg;
      width = 1;
    end else if (ps2_key_pressed === 1'b1) begin
      width = width + 1;
    end
    if (ps2_key_pressed !== 1'b1 && kp_q === 1'b1 && width != 4) bad_width = bad_width + 1;
    if (frame_error === 1'b1) begin
      if (fe_q !== 1'b1) ferr_cnt = ferr_cnt + 1;
      fe_width = fe_width + 1;
    end else begin
      if (fe_q === 1'b1 && fe_width != 1) bad_fe = bad_fe + 1;
      fe_width = 0;
    end
    kp_q = ps2_key_pressed; fe_q = frame_error;
    kd_q = ps2_key_data; out_q = ps2_out;
  end

  // byte-level reference model
  logic [7:0] m_out = 8'h00, m_kd = 8'h00, m_held = 8'h00;
  logic       m_brk = 1'b0;
  int         m_strobes = 0, m_errs = 0;

  task automatic model_byte(input logic [7:0] b);
    m_out = b;
    if (b == 8'hE0) begin
    end else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      if (b == m_held) m_held = 8'h00;
      m_brk = 1'b0;
    end else if (b != m_held) begin
      m_kd = b; m_held = b; m_strobes = m_strobes + 1;
    end
  endtask

  task automatic model_error();
    m_brk = 1'b0;
    m_errs = m_errs + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    ps2_dat = v;
    repeat (half) @(posedge clock);
    ps2_clk = 1'b0;
    repeat (half) @(posedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b) ^ bad_par);
    drive_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (16) @(posedge clock);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_byte(b);
  endtask

  task automatic check_model(input string tag);
    @(negedge clock);
    chk({tag, ".out"}, {24'd0, ps2_out}, {24'd0, m_out});
    chk({tag, ".key"}, {24'd0, ps2_key_data}, {24'd0, m_kd});
    chk({tag, ".strobes"}, strobe_cnt, m_strobes);
    chk({tag, ".ferrs"}, ferr_cnt, m_errs);
    chk({tag, ".strobe_width_bad"}, bad_width, 0);
    chk({tag, ".ferr_width_bad"}, bad_fe, 0);
  endtask

  logic [7:0] pool [4] = '{8'h1C, 8'h74, 8'h2D, 8'h42};
  int s0;

  initial begin
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("rst.key", {24'd0, ps2_key_data}, 32'h0);
    chk("rst.out", {24'd0, ps2_out}, 32'h0);
    chk("rst.pressed", {31'd0, ps2_key_pressed}, 32'h0);
    chk("rst.ferr", {31'd0, frame_error}, 32'h0);
    reset = 1'b0;
    repeat (4) @(posedge clock);

    // single make: strobe timing relative to the data update
    send_good(8'h1C);
    check_model("make1C");
    chk("make1C.rise_after_key", rise_lag, 1);
    chk("make1C.rise_after_out", out_lag, 1);

    // release, then typematic group with exactly one strobe
    send_good(8'hF0); send_good(8'h1C);
    s0 = strobe_cnt;
    send_good(8'h1C); send_good(8'h1C); send_good(8'h1C);
    send_good(8'hF0); send_good(8'h1C);
    check_model("typematic");
    chk("typematic.one_strobe", strobe_cnt - s0, 1);
    send_good(8'h1C);
    check_model("remake1C");

    // extended key press and release
    s0 = strobe_cnt;
    send_good(8'hE0); send_good(8'h74);
    check_model("ext74");
    chk("ext74.rise_after_key", rise_lag, 1);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
    check_model("ext74rel");
    chk("ext74.strobes", strobe_cnt - s0, 1);

    // bad parity, then the same byte valid
    send_frame(8'h16, 1'b1, 1'b0);
    model_error();
    check_model("badpar16");
    send_good(8'h16);
    check_model("good16");

    // timeout after start + 3 data bits
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (TIMEOUT + 20) @(posedge clock);
    model_error();
    check_model("timeout");
    send_good(8'h2D);
    check_model("after_timeout2D");

    // short clock glitch with data low must not start a frame
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (5) @(posedge clock);
    ps2_clk = 1'b1;
    repeat (20) @(posedge clock);
    ps2_dat = 1'b1;
    repeat (4) @(posedge clock);
    send_good(8'h5A);
    check_model("glitch");

    // reset in the middle of the data bits
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    ps2_clk = 1'b0;
    repeat (half) @(posedge clock);
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("midrst.key", {24'd0, ps2_key_data}, 32'h0);
    chk("midrst.out", {24'd0, ps2_out}, 32'h0);
    chk("midrst.pressed", {31'd0, ps2_key_pressed}, 32'h0);
    chk("midrst.ferr", {31'd0, frame_error}, 32'h0);
    m_out = 8'h00; m_kd = 8'h00; m_held = 8'h00; m_brk = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    send_good(8'h42);
    check_model("after_reset42");

    // random byte stream with occasional corrupted frames
    for (int n = 0; n < 30; n++) begin
      int r;
      logic [7:0] b;
      half = int'($urandom_range(10, 16));
      r = int'($urandom_range(0, 9));
      if (r == 0) send_good(8'hE0);
      else if (r == 1) send_good(8'hF0);
      else if (r == 9) begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 0) send_frame(b, 1'b1, 1'b0);
        else send_frame(b, 1'b0, 1'b1);
        model_error();
      end else send_good(pool[$urandom_range(0, 3)]);
      check_model("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
